// File: rtl/screen_scan.sv
// screen_scan -- walks a 1-bit-per-pixel framebuffer in memory and streams it
// out one pixel at a time, row-major, MSB of each byte leftmost.
//
// Optional feature: define SCREEN_SCAN_PREFETCH_EN to add a one-byte prefetch
// buffer. While a byte is being shifted out, the next byte is fetched so that
// consecutive bytes stream without bubble cycles. Without the macro every byte
// goes through a FETCH state.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle request to scan a frame (ignored unless idle)
//   busy              high whenever the scanner is not idle
//   mem_read          read request to the memory arbiter (dropped in ack cycle)
//   mem_read_idx      12-bit read address, 0 when no request
//   mem_read_byte     read data, valid with mem_read_ack
//   mem_read_ack      one-cycle read completion
//   pix_valid/ready   pixel handshake: a pixel transfers on a cycle where both
//                     are high; while valid && !ready the pixel outputs hold
//                     steady. valid never depends on ready.
//   pix_data          pixel value (1 = lit)
//   pix_x, pix_y      pixel column / row
//   frame_done        one-cycle pulse the cycle after the last pixel transfers
//   dbg_state         current FSM state (IDLE=0, FETCH=1, SHIFT=2)

module screen_scan #(
    parameter logic [11:0] BASE_ADDR = 12'h100,
    parameter int          ROW_BYTES = 8,
    parameter int          ROWS      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic [7:0]  mem_read_byte,
    input  logic        mem_read_ack,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [5:0]  pix_x,
    output logic [4:0]  pix_y,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);

    localparam int TOTAL = ROW_BYTES * ROWS;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_done_q, frame_done_d;
    logic             pf_req;

`ifdef SCREEN_SCAN_PREFETCH_EN
    logic [7:0] pf_buf_q, pf_buf_d;
    logic       pf_valid_q, pf_valid_d;

    // Ask for the next byte as soon as the buffer is free; the last byte of
    // the frame has no successor.
    assign pf_req = (state_q == ST_SHIFT) && !pf_valid_q && (byte_idx_q != LAST_IDX);
`else
    assign pf_req = 1'b0;
`endif

    // ---------------- outputs (state registers only, plus ack for mem_read)
    always_comb begin
        busy         = (state_q != ST_IDLE);
        mem_read     = ((state_q == ST_FETCH) || pf_req) && !mem_read_ack;
        mem_read_idx = 12'd0;
        if (mem_read) begin
            if (state_q == ST_FETCH) begin
                mem_read_idx = BASE_ADDR + 12'(byte_idx_q);
            end else begin
                mem_read_idx = BASE_ADDR + 12'(byte_idx_q) + 12'd1;
            end
        end
        pix_valid = (state_q == ST_SHIFT);
        pix_data  = 1'b0;
        pix_x     = 6'd0;
        pix_y     = 5'd0;
        if (pix_valid) begin
            pix_data = shift_q[7];
            pix_x    = 6'((int'(byte_idx_q) % ROW_BYTES) * 8 + int'(bit_cnt_q));
            pix_y    = 5'(int'(byte_idx_q) / ROW_BYTES);
        end
        frame_done = frame_done_q;
        dbg_state  = state_q;
    end

    // ---------------- next state
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
`ifdef SCREEN_SCAN_PREFETCH_EN
        pf_buf_d     = pf_buf_q;
        pf_valid_d   = pf_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    byte_idx_d = '0;
                    bit_cnt_d  = 3'd0;
                    state_d    = ST_FETCH;
`ifdef SCREEN_SCAN_PREFETCH_EN
                    pf_valid_d = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                if (mem_read_ack) begin
                    shift_d   = mem_read_byte;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
`ifdef SCREEN_SCAN_PREFETCH_EN
                if (pf_req && mem_read_ack) begin
                    pf_buf_d   = mem_read_byte;
                    pf_valid_d = 1'b1;
                end
`endif
                // pix_valid is always high here, so ready alone means transfer.
                if (pix_ready) begin
                    if (bit_cnt_q != 3'd7) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (byte_idx_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
`ifdef SCREEN_SCAN_PREFETCH_EN
                        bit_cnt_d = 3'd0;
                        if (pf_valid_q) begin
                            shift_d    = pf_buf_q;
                            pf_valid_d = 1'b0;
                        end else if (pf_req && mem_read_ack) begin
                            // Data landing on the same edge bypasses the buffer.
                            shift_d    = mem_read_byte;
                            pf_valid_d = 1'b0;
                        end else begin
                            state_d = ST_FETCH;
                        end
`else
                        state_d = ST_FETCH;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            frame_done_q <= 1'b0;
`ifdef SCREEN_SCAN_PREFETCH_EN
            pf_buf_q     <= 8'd0;
            pf_valid_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_done_q <= frame_done_d;
`ifdef SCREEN_SCAN_PREFETCH_EN
            pf_buf_q     <= pf_buf_d;
            pf_valid_q   <= pf_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_screen_scan.sv
// tb_screen_scan -- self-checking bench for screen_scan (default parameters:
// base 0x100, 8 bytes per row, 32 rows). The expected pixel stream and read
// address sequence are derived from a memory image; a compare process checks
// the DUT against them every cycle. Builds with or without
// SCREEN_SCAN_PREFETCH_EN.

module tb_screen_scan;

    localparam int NBYTES = 256;
    localparam int NPIX   = 2048;
`ifdef SCREEN_SCAN_PREFETCH_EN
    localparam int EXP_SPAN = 2048;   // first valid pixel to frame_done, no bubbles
`else
    localparam int EXP_SPAN = 2558;   // 255 bytes * (1 req + 1 ack + 8 px) + 8 px
`endif

    // ---------------- clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start, busy, mem_read, mem_read_ack, pix_valid, pix_ready;
    logic        pix_data, frame_done;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;
    logic [1:0]  dbg_state;

    screen_scan dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .mem_read(mem_read), .mem_read_idx(mem_read_idx),
        .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done),
        .dbg_state(dbg_state)
    );

    // ---------------- model state / scoreboard
    logic [7:0]  mem [NBYTES];
    logic [11:0] exp_q[$];     // {data, x[5:0], y[4:0]}
    logic [11:0] addr_q[$];
    int  n_vec = 0, n_err = 0;
    int  lat = 1, ready_mode = 0;
    bit  frame_active = 1'b0, fd_exp = 1'b0;
    int  xfer_cnt = 0, cyc = 0, first_valid_cyc = -1, done_cyc = -1, ack_cnt = 0;
    logic [11:0] log_pix [8];
    logic [11:0] last_pix, first_ack_addr, last_ack_addr;
    bit  exp8 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};   // 0xA5, MSB first

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected frame: each byte gives 8 pixels left to right from its MSB.
    task automatic build_frame();
        exp_q.delete();
        addr_q.delete();
        for (int b = 0; b < NBYTES; b++) begin
            addr_q.push_back(12'h100 + 12'(b));
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back({mem[b][7-k], 6'((b % 8) * 8 + k), 5'(b / 8)});
            end
        end
    endtask

    // ---------------- driver tasks
    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        build_frame();
        frame_active    = 1'b1;
        xfer_cnt        = 0;
        ack_cnt         = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
    endtask

    task automatic wait_frame(input int budget);
        int n;
        n = 0;
        while (done_cyc < 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (done_cyc < 0) begin
            n_err++;
            $display("FAIL frame_timeout: no frame_done after %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
        chk("xfer_count", xfer_cnt, NPIX);
        chk("pixels_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
    endtask

    // ---------------- pixel consumer: ready always, or pattern 1,0,0,1
    initial begin
        int k;
        k = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) pix_ready = 1'b1;
            else                 pix_ready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
        end
    end

    // ---------------- memory responder: ack after 'lat' request cycles
    initial begin
        int held;
        logic [11:0] req_addr;
        mem_read_ack  = 1'b0;
        mem_read_byte = 8'd0;
        held          = 0;
        req_addr      = 12'd0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mem_read_ack = 1'b0;
                held = 0;
                continue;
            end
            if (mem_read_ack) begin
                mem_read_ack  = 1'b0;
                mem_read_byte = 8'd0;
                held          = 0;
            end
            #1;
            if (mem_read && rst_n) begin
                if (held == 0) req_addr = mem_read_idx;
                else chk("req_addr_stable", mem_read_idx, req_addr);
                if (held == lat) begin
                    mem_read_ack  = 1'b1;
                    mem_read_byte = mem[8'(req_addr - 12'h100)];
                    #1;
                    chk("ack_cycle_mem_read", mem_read, 0);
                    chk("ack_cycle_idx", mem_read_idx, 0);
                    if (addr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_read: got %0h, expected none", req_addr);
                    end else begin
                        chk("read_addr", req_addr, addr_q.pop_front());
                    end
                    if (ack_cnt == 0) first_ack_addr = req_addr;
                    last_ack_addr = req_addr;
                    ack_cnt++;
                end else begin
                    held++;
                end
            end
        end
    end

    // ---------------- compare process (every cycle, away from the edge)
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                chk("frame_done", frame_done, fd_exp);
                fd_exp = 1'b0;
                if (frame_done) done_cyc = cyc;
                chk("busy", busy, frame_active);
                if (!busy) begin
                    chk("idle_pix_valid", pix_valid, 0);
                    chk("idle_mem_read", mem_read, 0);
                end
                if (pix_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_pixel: got %0h, expected none", {pix_data, pix_x, pix_y});
                    end else begin
                        chk("pixel", {pix_data, pix_x, pix_y}, exp_q[0]);
                        if (first_valid_cyc < 0) first_valid_cyc = cyc;
                        if (pix_ready) begin
                            if (xfer_cnt < 8) log_pix[xfer_cnt] = {pix_data, pix_x, pix_y};
                            last_pix = {pix_data, pix_x, pix_y};
                            xfer_cnt++;
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) begin
                                fd_exp       = 1'b1;
                                frame_active = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence
    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        for (int b = 0; b < NBYTES; b++) mem[b] = 8'($urandom_range(0, 255));
        mem[0] = 8'hA5;

        repeat (3) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_read_idx", mem_read_idx, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_xyd", {pix_data, pix_x, pix_y}, 0);
        chk("rst_frame_done", frame_done, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Frame 1: ready always, ack latency 1, stray start mid-frame.
        lat = 1; ready_mode = 0;
        do_start();
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_frame(6000);
        for (int i = 0; i < 8; i++) begin
            chk("first8_pixel", log_pix[i], {exp8[i], 6'(i), 5'd0});
        end
        chk("last_pixel_xy", last_pix[10:0], {6'd63, 5'd31});
        chk("first_read_addr", first_ack_addr, 12'h100);
        chk("last_read_addr", last_ack_addr, 12'h1FF);
        chk("read_count", ack_cnt, NBYTES);
        chk("frame_span", done_cyc - first_valid_cyc, EXP_SPAN);

        // Frame 2: consumer stalls with pattern 1,0,0,1.
        ready_mode = 1;
        do_start();
        wait_frame(12000);
        ready_mode = 0;

        // Frame 3: memory acks after 5 request cycles.
        lat = 5;
        do_start();
        wait_frame(8000);
        lat = 1;

        // Frame 4: reset at pixel 100, abandoned without frame_done.
        do_start();
        n = 0;
        while (xfer_cnt < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_pixel_100", xfer_cnt, 100);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_mem_read_idx", mem_read_idx, 0);
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_pix_xyd", {pix_data, pix_x, pix_y}, 0);
        chk("midrst_frame_done", frame_done, 0);
        exp_q.delete();
        addr_q.delete();
        frame_active = 1'b0;
        fd_exp       = 1'b0;
        done_cyc     = -1;
        repeat (3) @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_frame_done_after_rst", (done_cyc < 0) ? 0 : 1, 0);

        // Frame 5: fresh start after reset restarts from the top.
        do_start();
        wait_frame(6000);
        chk("restart_first_addr", first_ack_addr, 12'h100);
        chk("restart_first_pixel", log_pix[0], {1'b1, 6'd0, 5'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/screen_scan.md
SCREEN_SCAN -- requirements
Module: screen_scan

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h100, framebuffer start address.
REQ-002 SHALL have parameter ROW_BYTES, default 8, bytes per row (64 px).
REQ-003 SHALL have parameter ROWS, default 32, rows per frame.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to scan one frame.
REQ-007 SHALL have port busy, output, 1, high while not IDLE.
REQ-008 SHALL have port mem_read, output, 1, read request to memory arbiter.
REQ-009 SHALL have port mem_read_idx, output, 12, read address.
REQ-010 SHALL have port mem_read_byte, input, 8, read data, valid with ack.
REQ-011 SHALL have port mem_read_ack, input, 1, one-cycle read completion.
REQ-012 SHALL have port pix_valid, output, 1, pixel available.
REQ-013 SHALL have port pix_ready, input, 1, consumer accepts pixel.
REQ-014 SHALL have port pix_data, output, 1, pixel value (1 = lit).
REQ-015 SHALL have port pix_x, output, 6, pixel column 0..63.
REQ-016 SHALL have port pix_y, output, 5, pixel row 0..31.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse after last pixel accepted.

Function
REQ-018 SHALL implement states IDLE, FETCH, SHIFT; busy = (state != IDLE).
REQ-019 IDLE: start=1 SHALL clear byte index to 0 and enter FETCH; start outside IDLE SHALL be ignored.
REQ-020 FETCH: mem_read SHALL be 1 and mem_read_idx = BASE_ADDR + byte index (12-bit wrap) while mem_read_ack=0; both 0 in the ack cycle.
REQ-021 FETCH: on mem_read_ack SHALL latch mem_read_byte into 8-bit shift register, clear bit counter, enter SHIFT next cycle.
REQ-022 SHIFT: pix_valid=1, pix_data = shift[7] (MSB leftmost), pix_x = (byte index mod ROW_BYTES)*8 + bit counter, pix_y = byte index / ROW_BYTES.
REQ-023 Transfer occurs only when pix_valid && pix_ready; pix_data/pix_x/pix_y SHALL stay stable while pix_valid && !pix_ready.
REQ-024 On transfer with bit counter < 7: shift left by one, bit counter +1.
REQ-025 On transfer with bit counter = 7 and byte index < ROW_BYTES*ROWS-1: byte index +1, enter FETCH.
REQ-026 On transfer of last pixel (byte index = ROW_BYTES*ROWS-1, bit 7): enter IDLE, assert frame_done for exactly the next cycle.
REQ-027 pix_valid, mem_read, frame_done SHALL be 0 in IDLE; mem_read_ack in IDLE or SHIFT (prefetch disabled) SHALL be ignored.
REQ-028 Outputs mem_read, mem_read_idx, pix_valid, pix_data, pix_x, pix_y SHALL be combinational from state registers only, except mem_read's dependence on mem_read_ack.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, busy=0, mem_read=0, mem_read_idx=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, frame_done=0, and clear byte index, bit counter, shift and prefetch registers.
REQ-030 Reset mid-frame SHALL abandon the frame without frame_done; next scan SHALL start only on a new start after rst_n=1.

Configuration
REQ-031 Macro SCREEN_SCAN_PREFETCH_EN SHALL enable an 8-bit prefetch buffer with valid flag.
REQ-032 With macro: during SHIFT, if buffer empty and byte index not last, mem_read SHALL request byte index+1; ack fills buffer; at bit-7 transfer with buffer full, shift register loads buffer and SHIFT continues with zero bubble cycles; buffer empty SHALL fall back to FETCH.
REQ-033 Without macro: no prefetch; minimum one FETCH cycle plus ack latency between bytes.

Verification
REQ-034 Memory 0x100=0xA5, ack 1 cycle after request, pix_ready=1, start -> first 8 pixels 1,0,1,0,0,1,0,1 at pix_x 0..7, pix_y 0.
REQ-035 Full frame, pix_ready=1 -> exactly 2048 transfers, addresses 0x100..0x1FF in order, last pixel x=63 y=31, frame_done one cycle.
REQ-036 pix_ready toggling 1,0,0,1 pattern -> no pixel lost/duplicated, outputs stable while stalled.
REQ-037 Ack delayed 5 cycles -> mem_read held high 5 cycles at same mem_read_idx, then dropped in ack cycle.
REQ-038 rst_n low at pixel 100 -> all outputs zero immediately; start after release -> scan restarts at 0x100, x=0 y=0.
REQ-039 With SCREEN_SCAN_PREFETCH_EN, ack latency 1, pix_ready=1 -> pix_valid continuously high for 2048 cycles.
